// File: rtl/cpuori_mul_seq.sv
// Two-pass 32x32 multiply sequencer driving a 32x16-capable multiplier cell.
// Each request makes two passes through the cell. The two partial products are recombined,
// optionally accumulated, and held for a valid/ready consumer.
module cpuori_mul_seq #(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_valid,
    output logic        mul_ready,
    input  logic [31:0] mul_src1,
    input  logic [31:0] mul_src2,
    input  logic        mul_acc,
    input  logic        acc_clr,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    input  logic [31:0] cell_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy
);

    localparam int CNT_W = (CELL_LAT < 1) ? 1 : $clog2(CELL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      lo_r;
    logic [31:0]      acc_reg_r;
    logic             acc_flag_r;
    logic             accept_s;
    logic             phase_end_s;
    logic             res_fire_s;
    logic [31:0]      sum_s;

    // The high pass only contributes its low 16 bits, shifted into the upper half; carries past bit 31 drop.
    function automatic logic [31:0] recombine(
        input logic [31:0] lo,
        input logic [31:0] hi_res,
        input logic        acc_en,
        input logic [31:0] acc
    );
        logic [31:0] acc_term;
        acc_term  = acc_en ? acc : 32'h0000_0000;
        recombine = lo + {hi_res[15:0], 16'h0000} + acc_term;
    endfunction

    // Handshake and phase-completion strobes.
    always_comb begin
        accept_s    = 1'b0;
        phase_end_s = 1'b0;
        res_fire_s  = 1'b0;
        if (mul_valid && (state_r == S_IDLE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (cnt_r == CNT_LAST) begin
            phase_end_s = 1'b1;
        end else begin
            phase_end_s = 1'b0;
        end
        if (res_valid && res_ready) begin
            res_fire_s = 1'b1;
        end else begin
            res_fire_s = 1'b0;
        end
        sum_s = recombine(lo_r, cell_result, acc_flag_r, acc_reg_r);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_P1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_P1: begin
                if (phase_end_s) begin
                    state_next_s = S_P2;
                end else begin
                    state_next_s = S_P1;
                end
            end
            S_P2: begin
                if (phase_end_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_P2;
                end
            end
            S_DONE: begin
                if (res_fire_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-phase cycle counter; runs 0..CELL_LAT while operands are held on the cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if ((state_r == S_P1) || (state_r == S_P2)) begin
            if (phase_end_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Operand capture at acceptance; a clear in the same cycle suppresses accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r        <= 32'h0000_0000;
            b_r        <= 32'h0000_0000;
            acc_flag_r <= 1'b0;
        end else if (accept_s) begin
            a_r        <= mul_src1;
            b_r        <= mul_src2;
            acc_flag_r <= mul_acc & ~acc_clr;
        end
    end

    // Low-pass partial product and the running accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_r      <= 32'h0000_0000;
            acc_reg_r <= 32'h0000_0000;
        end else begin
            if ((state_r == S_P1) && phase_end_s) begin
                lo_r <= cell_result;
            end
            if ((state_r == S_IDLE) && acc_clr) begin
                acc_reg_r <= 32'h0000_0000;
            end else if ((state_r == S_P2) && phase_end_s && acc_flag_r) begin
                acc_reg_r <= sum_s;
            end
        end
    end

    // Cell operands are loaded one edge ahead of each phase so they are stable for the whole phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_src1 <= 32'h0000_0000;
            cell_src2 <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        cell_src1 <= mul_src1;
                        cell_src2 <= {16'h0000, mul_src2[15:0]};
                    end else begin
                        cell_src1 <= 32'h0000_0000;
                        cell_src2 <= 32'h0000_0000;
                    end
                end
                S_P1: begin
                    if (phase_end_s) begin
                        cell_src1 <= a_r;
                        cell_src2 <= {16'h0000, b_r[31:16]};
                    end
                end
                S_P2: begin
                    if (phase_end_s) begin
                        cell_src1 <= 32'h0000_0000;
                        cell_src2 <= 32'h0000_0000;
                    end
                end
                S_DONE: begin
                    cell_src1 <= 32'h0000_0000;
                    cell_src2 <= 32'h0000_0000;
                end
                default: begin
                    cell_src1 <= 32'h0000_0000;
                    cell_src2 <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Result register, held until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data  <= 32'h0000_0000;
            res_valid <= 1'b0;
        end else if ((state_r == S_P2) && phase_end_s) begin
            res_data  <= sum_s;
            res_valid <= 1'b1;
        end else if ((state_r == S_DONE) && res_fire_s) begin
            res_valid <= 1'b0;
        end
    end

    // Status outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            mul_ready <= (state_next_s == S_IDLE);
            busy      <= (state_next_s != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cpuori_mul_seq.sv
// Self-checking bench for cpuori_mul_seq: behavioural multiplier cells, a scoreboard queue of
// expected results, and one task per scenario. Covers CELL_LAT=1 and CELL_LAT=3.
module tb_cpuori_mul_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m1_valid, m1_ready, m1_acc, m1_clr, m1_res_valid, m1_res_ready, m1_busy;
    logic [31:0] m1_src1, m1_src2, m1_cell_src1, m1_cell_src2, m1_cell_result, m1_res_data;
    logic        m3_valid, m3_ready, m3_acc, m3_clr, m3_res_valid, m3_res_ready, m3_busy;
    logic [31:0] m3_src1, m3_src2, m3_cell_src1, m3_cell_src2, m3_cell_result, m3_res_data;

    int          compared = 0;
    int          mismatched = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_model = 32'h0;

    cpuori_mul_seq #(.CELL_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .mul_valid(m1_valid), .mul_ready(m1_ready),
        .mul_src1(m1_src1), .mul_src2(m1_src2), .mul_acc(m1_acc), .acc_clr(m1_clr),
        .cell_src1(m1_cell_src1), .cell_src2(m1_cell_src2), .cell_result(m1_cell_result),
        .res_valid(m1_res_valid), .res_ready(m1_res_ready), .res_data(m1_res_data), .busy(m1_busy)
    );

    cpuori_mul_seq #(.CELL_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .mul_valid(m3_valid), .mul_ready(m3_ready),
        .mul_src1(m3_src1), .mul_src2(m3_src2), .mul_acc(m3_acc), .acc_clr(m3_clr),
        .cell_src1(m3_cell_src1), .cell_src2(m3_cell_src2), .cell_result(m3_cell_result),
        .res_valid(m3_res_valid), .res_ready(m3_res_ready), .res_data(m3_res_data), .busy(m3_busy)
    );

    // Behavioural multiplier cells with 1 and 3 cycles of latency.
    logic [31:0] cell1_r;
    logic [31:0] cell3_r [3];
    always @(posedge clk) begin
        cell1_r    <= m1_cell_src1 * m1_cell_src2;
        cell3_r[0] <= m3_cell_src1 * m3_cell_src2;
        cell3_r[1] <= cell3_r[0];
        cell3_r[2] <= cell3_r[1];
    end
    assign m1_cell_result = cell1_r;
    assign m3_cell_result = cell3_r[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one request into the CELL_LAT=1 instance and push its reference result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic acc, input logic clr,
                         output bit ok, output int unsigned acc_cyc);
        int n;
        logic [31:0] e;
        n = 0;
        m1_src1 = a; m1_src2 = b; m1_acc = acc; m1_clr = clr; m1_valid = 1'b1;
        while (m1_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        if (clr) acc_model = 32'h0;
        e = a * b;
        if (acc && !clr) begin
            e = e + acc_model;
            acc_model = e;
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        m1_valid = 1'b0; m1_acc = 1'b0; m1_clr = 1'b0;
        m1_src1 = $urandom; m1_src2 = $urandom;
    endtask

    // Wait (bounded) for a result, record it, then take it with a one-cycle res_ready pulse.
    task automatic collect(output logic [31:0] data, output int unsigned vcyc, output bit ok);
        int n;
        n = 0;
        while (m1_res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        data = m1_res_data;
        vcyc = cyc;
        m1_res_ready = 1'b1;
        @(negedge clk);
        m1_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m1_valid = 1'b0; m1_src1 = 32'h0; m1_src2 = 32'h0; m1_acc = 1'b0; m1_clr = 1'b0; m1_res_ready = 1'b0;
        m3_valid = 1'b0; m3_src1 = 32'h0; m3_src2 = 32'h0; m3_acc = 1'b0; m3_clr = 1'b0; m3_res_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++; if (m1_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", m1_ready); end
        compared++; if (m1_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", m1_busy); end
        compared++; if (m1_res_valid !== 1'b0) begin mismatched++; $display("FAIL reset_res_valid: got %b want 0", m1_res_valid); end
        compared++; if (m1_res_data !== 32'h0) begin mismatched++; $display("FAIL reset_res_data: got %h want 0", m1_res_data); end
        compared++; if ({m1_cell_src1, m1_cell_src2} !== 64'h0) begin mismatched++; $display("FAIL reset_cell_src: got %h/%h want 0/0", m1_cell_src1, m1_cell_src2); end
        compared++; if (m3_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_lat3: got %b want 1", m3_ready); end
    endtask

    task automatic test_basic();
        bit ok1, ok2; int unsigned ta, tv; logic [31:0] d, e;
        issue(32'h12345678, 32'h00000010, 1'b0, 1'b0, ok1, ta);
        collect(d, tv, ok2);
        e = exp_q.pop_front();
        compared++; if (!(ok1 && ok2)) begin mismatched++; $display("FAIL basic_timeout: accept=%0b result=%0b want 1/1", ok1, ok2); end
        compared++; if (d !== e) begin mismatched++; $display("FAIL basic_data: got %h want %h", d, e); end
        compared++; if (d !== 32'h23456780) begin mismatched++; $display("FAIL basic_const: got %h want 23456780", d); end
        compared++; if (tv - ta !== 32'd4) begin mismatched++; $display("FAIL basic_latency: got %0d want 4", tv - ta); end
    endtask

    task automatic test_high_half();
        bit ok1, ok2; int unsigned ta, tv; logic [31:0] d, e;
        issue(32'h00010003, 32'h00020005, 1'b0, 1'b0, ok1, ta);
        compared++; if (m1_cell_src2 !== 32'h5 || m1_cell_src1 !== 32'h00010003) begin mismatched++; $display("FAIL p1_operands: got %h/%h want 00010003/00000005", m1_cell_src1, m1_cell_src2); end
        compared++; if (m1_busy !== 1'b1 || m1_ready !== 1'b0) begin mismatched++; $display("FAIL p1_status: busy=%b ready=%b want 1/0", m1_busy, m1_ready); end
        repeat (2) @(negedge clk);
        compared++; if (m1_cell_src2 !== 32'h2 || m1_cell_src1 !== 32'h00010003) begin mismatched++; $display("FAIL p2_operands: got %h/%h want 00010003/00000002", m1_cell_src1, m1_cell_src2); end
        collect(d, tv, ok2);
        e = exp_q.pop_front();
        compared++; if (!ok1 || !ok2 || d !== e || d !== 32'h000B000F) begin mismatched++; $display("FAIL high_half_data: got %h want %h", d, e); end
        compared++; if ({m1_cell_src1, m1_cell_src2} !== 64'h0) begin mismatched++; $display("FAIL idle_cell_src: got %h/%h want 0/0", m1_cell_src1, m1_cell_src2); end
    endtask

    task automatic test_wrap();
        logic [31:0] ta_a [2] = '{32'hFFFFFFFF, 32'h80000000};
        logic [31:0] ta_b [2] = '{32'hFFFFFFFF, 32'h00000002};
        logic [31:0] tk   [2] = '{32'h00000001, 32'h00000000};
        for (int i = 0; i < 2; i++) begin
            bit ok1, ok2; int unsigned ta, tv; logic [31:0] d, e;
            issue(ta_a[i], ta_b[i], 1'b0, 1'b0, ok1, ta);
            collect(d, tv, ok2);
            e = exp_q.pop_front();
            compared++; if (!ok1 || !ok2 || d !== e || d !== tk[i]) begin mismatched++; $display("FAIL wrap_%0d: got %h want %h", i, d, tk[i]); end
        end
    endtask

    task automatic test_accumulate();
        logic [31:0] ta_a [3] = '{32'd3, 32'd5, 32'd2};
        logic [31:0] ta_b [3] = '{32'd4, 32'd6, 32'd2};
        logic        tclr [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] tk   [3] = '{32'h0000000C, 32'h0000002A, 32'h00000004};
        @(negedge clk); m1_clr = 1'b1;
        @(negedge clk); m1_clr = 1'b0;
        acc_model = 32'h0;
        for (int i = 0; i < 3; i++) begin
            bit ok1, ok2; int unsigned ta, tv; logic [31:0] d, e;
            issue(ta_a[i], ta_b[i], 1'b1, tclr[i], ok1, ta);
            collect(d, tv, ok2);
            e = exp_q.pop_front();
            compared++; if (!ok1 || !ok2 || d !== e || d !== tk[i]) begin mismatched++; $display("FAIL acc_%0d: got %h want %h", i, d, tk[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2; int unsigned ta, tv; logic [31:0] d, d0, e; int n;
        issue(32'h00001234, 32'h00000100, 1'b0, 1'b0, ok1, ta);
        n = 0;
        while (m1_res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        d0 = m1_res_data;
        e = exp_q.pop_front();
        compared++; if (n >= 100 || d0 !== e) begin mismatched++; $display("FAIL bp_first: got %h want %h", d0, e); end
        m1_valid = 1'b1; m1_src1 = 32'h0000BEEF; m1_src2 = 32'h00000003; m1_acc = 1'b0; m1_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++; if (m1_res_valid !== 1'b1 || m1_res_data !== d0 || m1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold_%0d: valid=%b data=%h ready=%b want 1/%h/0", i, m1_res_valid, m1_res_data, m1_ready, d0); end
        end
        m1_res_ready = 1'b1;
        @(negedge clk);
        m1_res_ready = 1'b0;
        compared++; if (m1_ready !== 1'b1 || m1_res_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", m1_ready, m1_res_valid); end
        exp_q.push_back(32'h0000BEEF * 32'h00000003);
        @(posedge clk);
        @(negedge clk);
        ta = cyc;
        m1_valid = 1'b0;
        compared++; if (m1_busy !== 1'b1 || m1_ready !== 1'b0) begin mismatched++; $display("FAIL bp_next_accept: busy=%b ready=%b want 1/0", m1_busy, m1_ready); end
        collect(d, tv, ok2);
        e = exp_q.pop_front();
        compared++; if (!ok2 || d !== e || tv - ta !== 32'd4) begin mismatched++; $display("FAIL bp_second: got %h lat %0d want %h lat 4", d, tv - ta, e); end
    endtask

    task automatic test_reset_mid_op();
        bit ok1, ok2; int unsigned ta, tv; logic [31:0] d, e;
        issue(32'h00000011, 32'h00220022, 1'b0, 1'b0, ok1, ta);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        compared++; if (m1_busy !== 1'b1 || m1_cell_src2 !== 32'h22) begin mismatched++; $display("FAIL rst_pre_p2: busy=%b cell_src2=%h want 1/00000022", m1_busy, m1_cell_src2); end
        #2 reset = 1'b1;
        #1;
        acc_model = 32'h0;
        compared++; if (m1_busy !== 1'b0 || m1_res_valid !== 1'b0 || m1_res_data !== 32'h0) begin mismatched++; $display("FAIL rst_async_out: busy=%b valid=%b data=%h want 0/0/0", m1_busy, m1_res_valid, m1_res_data); end
        compared++; if ({m1_cell_src1, m1_cell_src2} !== 64'h0 || m1_ready !== 1'b1) begin mismatched++; $display("FAIL rst_async_cell: %h/%h ready=%b want 0/0/1", m1_cell_src1, m1_cell_src2, m1_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++; if (m1_res_valid !== 1'b0) begin mismatched++; $display("FAIL rst_no_valid_%0d: got %b want 0", i, m1_res_valid); end
        end
        issue(32'd7, 32'd9, 1'b1, 1'b0, ok1, ta);
        collect(d, tv, ok2);
        e = exp_q.pop_front();
        compared++; if (!ok1 || !ok2 || d !== e || d !== 32'h0000003F) begin mismatched++; $display("FAIL rst_after_op: got %h want 0000003f", d); end
    endtask

    task automatic test_lat3();
        int n; int unsigned ta, tv; logic [31:0] d, e;
        m3_src1 = 32'h12345678; m3_src2 = 32'h00000010; m3_acc = 1'b0; m3_clr = 1'b0; m3_valid = 1'b1;
        n = 0;
        while (m3_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        exp_q.push_back(32'h12345678 * 32'h00000010);
        @(posedge clk);
        @(negedge clk);
        ta = cyc;
        m3_valid = 1'b0; m3_src1 = $urandom; m3_src2 = $urandom;
        n = 0;
        while (m3_res_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        tv = cyc;
        d = m3_res_data;
        m3_res_ready = 1'b1;
        @(negedge clk);
        m3_res_ready = 1'b0;
        e = exp_q.pop_front();
        compared++; if (n >= 100 || d !== e || d !== 32'h23456780) begin mismatched++; $display("FAIL lat3_data: got %h want %h", d, e); end
        compared++; if (tv - ta !== 32'd8) begin mismatched++; $display("FAIL lat3_latency: got %0d want 8", tv - ta); end
        compared++; if (m3_ready !== 1'b1 || m3_busy !== 1'b0) begin mismatched++; $display("FAIL lat3_idle: ready=%b busy=%b want 1/0", m3_ready, m3_busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_high_half();
        test_wrap();
        test_accumulate();
        test_backpressure();
        test_reset_mid_op();
        test_lat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog expired");
    end

endmodule
